// File: rtl/seq_detect_prog_if.sv
// Serial-input and configuration bundle for seq_detect_prog.
// master drives stimulus/config, slave is the detector.
interface seq_detect_prog_if #(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1),
    parameter int CNT_W = 8
);
    logic             din;
    logic             din_valid;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             y;
    logic [LEN_W-1:0] fill;
    logic [CNT_W-1:0] match_count;

    modport master (
        output din, din_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  y, fill, match_count
    );

    modport slave (
        input  din, din_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output y, fill, match_count
    );
endinterface

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector with Mealy match pulse.
// Optional saturating match counter enabled by SEQ_DETECT_MATCH_CNT_EN.
module seq_detect_prog #(
    parameter int               PAT_W       = 8,
    parameter int               LEN_W       = $clog2(PAT_W + 1),
    parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(8'b0000_1101),
    parameter int               DEF_LEN     = 4,
    parameter int               CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    seq_detect_prog_if.slave   bus
);
    typedef logic [LEN_W-1:0] len_t;

    logic [PAT_W-1:0] hist_q;
    logic [PAT_W-1:0] pat_q;
    len_t             len_q;
    len_t             fill_q;
    logic             overlap_q;

    logic [PAT_W-1:0] cand;
    logic [PAT_W-1:0] mask;
    len_t             eff_len;
    len_t             fill_n;
    logic             match;

    // Compare only the low eff_len bits; fill must cover the whole pattern.
    always_comb begin
        eff_len = (len_q > len_t'(PAT_W)) ? len_t'(PAT_W) : len_q;
        cand    = {hist_q[PAT_W-2:0], bus.din};
        fill_n  = (fill_q >= len_t'(PAT_W)) ? len_t'(PAT_W) : fill_q + len_t'(1);
        mask    = '0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            mask[i] = (len_t'(i) < eff_len);
        end
        match = (eff_len != '0) && (fill_n >= eff_len) &&
                (((cand ^ pat_q) & mask) == '0);
    end

    assign bus.y    = !rst && bus.din_valid && !bus.cfg_load && match;
    assign bus.fill = rst ? '0 : fill_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q    <= '0;
            fill_q    <= '0;
            pat_q     <= DEF_PATTERN;
            len_q     <= len_t'(DEF_LEN);
            overlap_q <= 1'b1;
        end else if (bus.cfg_load) begin
            pat_q     <= bus.cfg_pattern;
            len_q     <= bus.cfg_len;
            overlap_q <= bus.cfg_overlap;
            hist_q    <= '0;
            fill_q    <= '0;
        end else if (bus.din_valid) begin
            hist_q <= cand;
            // Non-overlapping mode forgets the bits consumed by a match.
            fill_q <= (match && !overlap_q) ? '0 : fill_n;
        end
    end

`ifdef SEQ_DETECT_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || bus.cfg_load) begin
            cnt_q <= '0;
        end else if (bus.y && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.match_count = cnt_q;
`else
    assign bus.match_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Randomized bench for seq_detect_prog against a queue-based reference model,
// plus directed sequences with hand-computed match positions.
module tb_seq_detect_prog;
    localparam int PAT_W = 8;
    localparam int LEN_W = 4;
`ifdef SEQ_DETECT_MATCH_CNT_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 8;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_detect_prog_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    seq_detect_prog #(
        .PAT_W      (PAT_W),
        .LEN_W      (LEN_W),
        .DEF_PATTERN(8'b0000_1101),
        .DEF_LEN    (4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model: bits received since the last clear, newest at the back.
    bit             hq[$];
    int             m_len = 4;
    bit [PAT_W-1:0] m_pat = 8'b0000_1101;
    bit             m_ovl = 1'b1;
    int             m_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Match when the newest eff bits (din last) spell the pattern, pattern bit 0 = newest.
    function automatic bit model_y();
        int eff;
        int fn;
        bit b;
        if (rst || !bus.din_valid || bus.cfg_load) return 1'b0;
        eff = (m_len > PAT_W) ? PAT_W : m_len;
        if (eff == 0) return 1'b0;
        fn = hq.size() + 1;
        if (fn > PAT_W) fn = PAT_W;
        if (fn < eff) return 1'b0;
        for (int k = 0; k < eff; k++) begin
            b = (k == 0) ? bus.din : hq[hq.size() - k];
            if (b != m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        bit m;
        m = model_y();
        if (rst) begin
            hq.delete();
            m_len = 4; m_pat = 8'b0000_1101; m_ovl = 1'b1; m_cnt = 0;
        end else if (bus.cfg_load) begin
            m_pat = bus.cfg_pattern; m_len = int'(bus.cfg_len); m_ovl = bus.cfg_overlap;
            hq.delete();
            m_cnt = 0;
        end else if (bus.din_valid) begin
            hq.push_back(bus.din);
            if (hq.size() > PAT_W) void'(hq.pop_front());
            if (m && !m_ovl) hq.delete();
`ifdef SEQ_DETECT_MATCH_CNT_EN
            if (m && m_cnt < (1 << CNT_W) - 1) m_cnt++;
`endif
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_y", bus.y, model_y());
            chk("model_fill", bus.fill, rst ? 0 : hq.size());
`ifdef SEQ_DETECT_MATCH_CNT_EN
            chk("model_count", bus.match_count, m_cnt);
`else
            chk("model_count", bus.match_count, 0);
`endif
        end
    end

    task automatic cyc(input bit v, input bit d, input bit ld = 1'b0, input bit r = 1'b0);
        @(posedge clk);
        #1;
        rst = r; bus.din_valid = v; bus.din = d; bus.cfg_load = ld;
        @(negedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] p, input int l, input bit o);
        bus.cfg_pattern = p; bus.cfg_len = LEN_W'(l); bus.cfg_overlap = o;
        cyc(1'b1, 1'b1, 1'b1);
        chk("lit_load_y", bus.y, 0);
    endtask

    // bits are sent MSB first; exp_y bit n-1-i is the required y for bit i.
    task automatic stream(input string nm, input logic [31:0] bits, input int n,
                          input logic [31:0] exp_y);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, bits[n-1-i]);
            chk(nm, bus.y, exp_y[n-1-i]);
        end
    endtask

    initial begin
        bus.din = 1'b0; bus.din_valid = 1'b0; bus.cfg_load = 1'b0;
        bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("lit_rst_y", bus.y, 0);
        chk("lit_rst_fill", bus.fill, 0);
        cyc(1'b0, 1'b0);
        chk("lit_idle_fill", bus.fill, 0);

        // Default 1101, overlapping
        stream("lit_ovl", 32'b1101101, 7, 32'b0001001);
        cyc(1'b1, 1'b0);
        chk("lit_ovl_b8", bus.y, 0);
        cyc(1'b0, 1'b0);
        chk("lit_fill_sat", bus.fill, 8);

        // Non-overlapping
        load(8'b0000_1101, 4, 1'b0);
        stream("lit_novl_a", 32'b1101, 4, 32'b0001);
        cyc(1'b0, 1'b0);
        chk("lit_novl_fill0", bus.fill, 0);
        stream("lit_novl_b", 32'b101101, 6, 32'b000001);

        // Gaps in din_valid
        load(8'b0000_1101, 4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, (i < 2) ? 1'b1 : 1'b0);
            chk("lit_gap_bit", bus.y, 0);
            repeat (3) begin
                cyc(1'b0, 1'($urandom_range(0, 1)));
                chk("lit_gap_idle", bus.y, 0);
            end
        end
        cyc(1'b1, 1'b1);
        chk("lit_gap_final", bus.y, 1);

        load(8'b0000_0010, 3, 1'b1);
        stream("lit_010", 32'b01010, 5, 32'b00101);

        load(8'($urandom), 0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'($urandom_range(0, 1)));
            chk("lit_len0", bus.y, 0);
        end

        load(8'hA5, 12, 1'b1);
        stream("lit_len12", 32'hA5, 8, 32'h01);

        // Reset mid-sequence, then cfg_load on a final matching bit
        load(8'b0000_1101, 4, 1'b1);
        stream("lit_pre_rst", 32'b110, 3, 32'b000);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("lit_rst_mid_y", bus.y, 0);
        chk("lit_rst_mid_fill", bus.fill, 0);
        stream("lit_post_rst1", 32'b1, 1, 32'b0);
        stream("lit_post_rst2", 32'b1101, 4, 32'b0001);
        stream("lit_pre_ld", 32'b110, 3, 32'b000);
        bus.cfg_pattern = 8'b0000_1101; bus.cfg_len = 4'd4; bus.cfg_overlap = 1'b1;
        cyc(1'b1, 1'b1, 1'b1);
        chk("lit_ld_final_y", bus.y, 0);
        cyc(1'b0, 1'b0);
        chk("lit_ld_final_fill", bus.fill, 0);

`ifdef SEQ_DETECT_MATCH_CNT_EN
        load(8'b0000_0011, 2, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            cyc(1'b1, 1'b1);
            chk("lit_cnt_y", bus.y, (i >= 2) ? 1 : 0);
            chk("lit_cnt_val", bus.match_count, (i <= 2) ? 0 : ((i - 2 > 3) ? 3 : i - 2));
        end
        cyc(1'b0, 1'b0);
        chk("lit_cnt_sat", bus.match_count, 3);
        load(8'b0000_0011, 2, 1'b1);
        cyc(1'b0, 1'b0);
        chk("lit_cnt_clr", bus.match_count, 0);
`else
        load(8'b0000_0011, 2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1);
            chk("lit_cnt_tied", bus.match_count, 0);
        end
`endif

        // Randomized phase with occasional reconfiguration and reset
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 1) begin
                cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
            end else if (r < 4) begin
                bus.cfg_pattern = 8'($urandom);
                bus.cfg_len     = ($urandom_range(0, 9) < 8) ? LEN_W'($urandom_range(1, 4))
                                                             : LEN_W'($urandom_range(0, 15));
                bus.cfg_overlap = 1'($urandom_range(0, 1));
                cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            end else begin
                cyc(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            end
        end

        cyc(1'b0, 1'b0);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_detect_prog.md
Name: seq_detect_prog

Overview:
- Runtime-programmable serial bit-pattern detector: Mealy output pulse when the last `len` valid bits equal a loaded pattern.
- Pattern length up to PAT_W bits; overlapping or non-overlapping match mode; input qualified by a valid strobe.
- Sits on the serial input path of the fem_assignments datapath.
- Default configuration after reset is pattern "1101", overlapping.

Parameters:
PAT_W, 8, maximum pattern length in bits (>=2)
LEN_W, $clog2(PAT_W+1), width of length fields
DEF_PATTERN, 8'b0000_1101, pattern loaded at reset (low DEF_LEN bits significant)
DEF_LEN, 4, pattern length loaded at reset
CNT_W, 8, match counter width (optional feature only)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
din  input  1  serial data bit
din_valid  input  1  din is sampled only when high
cfg_load  input  1  latch cfg_pattern/cfg_len/cfg_overlap this cycle
cfg_pattern  input  PAT_W  new pattern; bit[len-1] = first bit received, bit[0] = last
cfg_len  input  LEN_W  new pattern length
cfg_overlap  input  1  1 = overlapping matches allowed, 0 = non-overlapping
y  output  1  match pulse, combinational (Mealy), same cycle as final matching bit
fill  output  LEN_W  number of valid history bits currently held (0..PAT_W)
match_count  output  CNT_W  saturating match count (MATCH_CNT_EN only)

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst: sampled at posedge clk only.
- State on reset: hist=0, fill=0, pat=DEF_PATTERN, len=DEF_LEN, overlap=1, match_count=0.
- Output values during reset: y=0, fill=0.
- Effective length eff_len = min(len, PAT_W). If eff_len=0, y is never asserted; history still updates.
- Per cycle with din_valid=1 and cfg_load=0:
  - cand = {hist[PAT_W-2:0], din}
  - fill_n = min(fill+1, PAT_W)
  - match = (fill_n >= eff_len) && (cand[eff_len-1:0] == pat[eff_len-1:0]) && (eff_len != 0)
- y = match; combinational from din, din_valid and registered state. y is 0 whenever din_valid=0, cfg_load=1 or rst=1.
- Next-state update at posedge:
  - hist <= cand
  - overlap=1, or overlap=0 without a match: fill <= fill_n
  - overlap=0 with a match: fill <= 0, so bits of a matched pattern are not reused
- din_valid=0: hist and fill hold. Gaps in valid do not break a sequence.
- cfg_load=1 (priority over din_valid):
  - pat <= cfg_pattern, len <= cfg_len, overlap <= cfg_overlap
  - hist <= 0, fill <= 0
  - din is discarded that cycle; y=0
  - New configuration applies from the next cycle.
- rst has priority over cfg_load and din_valid.
- Reset mid-sequence: partial history is discarded; y is not asserted until a full new pattern is received.
- cfg_len > PAT_W is clamped to PAT_W, per eff_len above.
- Bits of pat above eff_len are ignored.

Optional Feature:
- Macro: SEQ_DETECT_MATCH_CNT_EN.
- When defined:
  - match_count increments by 1 on every cycle with y=1.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - Cleared by rst and by cfg_load.
- When undefined: match_count is tied to 0 and no counter flops exist. The port list is unchanged.

Test Plan:
- After reset (default 1101, overlap), din_valid=1, stream 1,1,0,1,1,0,1 -> y=1 on bits 4 and 7 only; fill saturates at 8 by bit 8.
- cfg_load with pattern 1101, len 4, overlap=0, then stream 1,1,0,1,1,0,1 -> y=1 on bit 4 only, fill=0 after bit 4; stream continuing 1,0,1 -> y=1 on bit 10.
- Default config, bits 1,1,0 with din_valid=0 for 3 cycles between each bit, then 1 -> y=1 exactly on the final valid cycle; y=0 during all invalid cycles.
- cfg_load with pattern 3'b010, len 3, overlap=1, stream 0,1,0,1,0 -> y=1 on bits 3 and 5. cfg_len=0 with any stream -> y never 1. cfg_len=12 with PAT_W=8 -> behaves as len 8.
- Default config, send 1,1,0, assert rst one cycle, then send 1 -> y=0. Then 1,1,0,1 -> y=1 on its last bit. Assert cfg_load in the same cycle as a final matching bit -> y=0 and fill=0 next cycle.
- SEQ_DETECT_MATCH_CNT_EN defined, CNT_W=2, pattern "11" len 2, overlap=1, six 1s -> y on bits 2-6; match_count 1,2,3,3,3; cfg_load -> match_count=0.
